yadmc_wbarb: RTL and testbench

YADMC_WBARB -- requirements
Module: yadmc_wbarb

---
 rtl/yadmc_wbarb.sv | 180 ++++++++++++++++++
 tb/tb_yadmc_wbarb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/yadmc_wbarb.sv
// Three-master round-robin Wishbone arbiter in front of the memory controller slave port.
// Ownership lasts for the owner's whole cyc; an optional wait-for-ack limit aborts stuck cycles.
module yadmc_wbarb #(
  parameter int unsigned timeout = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  input  logic [31:0] m2_adr_i,
  input  logic [31:0] m2_dat_i,
  output logic [31:0] m2_dat_o,
  input  logic [3:0]  m2_sel_i,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam logic [15:0] TO_LAST = (timeout == 0) ? 16'd0 : 16'(timeout - 1);

  state_t      state_r;
  logic [1:0]  owner_r;
  logic [1:0]  last_r;
  logic [1:0]  grant_r;
  logic [15:0] wait_r;

  logic [2:0]  req_s;
  logic [1:0]  pick_s;
  logic        active_s;
  logic        timeout_s;
  logic [31:0] own_adr_s;
  logic [31:0] own_dat_s;
  logic [3:0]  own_sel_s;
  logic        own_cyc_s;
  logic        own_stb_s;
  logic        own_we_s;

  // First requester after 'last' in round-robin order; caller guarantees req is non-empty.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (req[c1]) begin
      return c1;
    end else if (req[c2]) begin
      return c2;
    end else begin
      return last;
    end
  endfunction

  // Request vector, next-owner choice and the selected owner's bus signals.
  always_comb begin
    req_s    = {m2_cyc_i & m2_stb_i, m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    pick_s   = rr_pick(req_s, last_r);
    active_s = (state_r == OWN);
    case (owner_r)
      2'd0: begin
        own_adr_s = m0_adr_i; own_dat_s = m0_dat_i; own_sel_s = m0_sel_i;
        own_cyc_s = m0_cyc_i; own_stb_s = m0_stb_i; own_we_s  = m0_we_i;
      end
      2'd1: begin
        own_adr_s = m1_adr_i; own_dat_s = m1_dat_i; own_sel_s = m1_sel_i;
        own_cyc_s = m1_cyc_i; own_stb_s = m1_stb_i; own_we_s  = m1_we_i;
      end
      2'd2: begin
        own_adr_s = m2_adr_i; own_dat_s = m2_dat_i; own_sel_s = m2_sel_i;
        own_cyc_s = m2_cyc_i; own_stb_s = m2_stb_i; own_we_s  = m2_we_i;
      end
      default: begin
        own_adr_s = 32'd0; own_dat_s = 32'd0; own_sel_s = 4'd0;
        own_cyc_s = 1'b0;  own_stb_s = 1'b0;  own_we_s  = 1'b0;
      end
    endcase
    // An ack in the limit cycle wins, so the abort never coincides with a delivered ack.
    timeout_s = (timeout != 0) && active_s && own_cyc_s && own_stb_s
                && !s_ack_i && (wait_r == TO_LAST);
  end

  // Slave request path and per-master response steering.
  always_comb begin
    if (active_s) begin
      s_adr_o = own_adr_s;
      s_dat_o = own_dat_s;
      s_sel_o = own_sel_s;
      s_cyc_o = own_cyc_s;
      s_stb_o = own_stb_s;
      s_we_o  = own_we_s;
    end else begin
      s_adr_o = 32'd0;
      s_dat_o = 32'd0;
      s_sel_o = 4'd0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
    end
    m0_ack_o = active_s && s_ack_i && (owner_r == 2'd0);
    m1_ack_o = active_s && s_ack_i && (owner_r == 2'd1);
    m2_ack_o = active_s && s_ack_i && (owner_r == 2'd2);
    m0_err_o = timeout_s && (owner_r == 2'd0);
    m1_err_o = timeout_s && (owner_r == 2'd1);
    m2_err_o = timeout_s && (owner_r == 2'd2);
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m2_dat_o = s_dat_i;
    grant_o  = grant_r;
  end

  // Ownership state machine with wait counter; reset leaves last=2 so m0 wins first.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= IDLE;
      owner_r <= 2'd0;
      last_r  <= 2'd2;
      grant_r <= 2'd3;
      wait_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          wait_r <= 16'd0;
          if (|req_s) begin
            owner_r <= pick_s;
            grant_r <= pick_s;
            state_r <= OWN;
          end else begin
            grant_r <= 2'd3;
          end
        end
        OWN: begin
          if (!own_cyc_s || timeout_s) begin
            last_r  <= owner_r;
            grant_r <= 2'd3;
            wait_r  <= 16'd0;
            state_r <= IDLE;
          end else if (s_ack_i || !own_stb_s) begin
            wait_r <= 16'd0;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 2'd3;
          wait_r  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yadmc_wbarb.sv
// Directed bench for yadmc_wbarb: arbitration order, hold, ack steering, timeout and reset.
module tb_yadmc_wbarb;

  logic        sys_clk;
  logic        sys_rst;
  logic [2:0]  cyc, stb, we;
  logic [31:0] adr [3];
  logic [31:0] wdat [3];
  logic [3:0]  sel [3];
  logic [31:0] rdat0, rdat1, rdat2;
  logic [2:0]  ack, err;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [1:0]  grant;

  int n_chk;
  int n_pass;
  int rr_exp [5] = '{0, 1, 2, 0, 1};

  yadmc_wbarb #(.timeout(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat0), .m0_sel_i(sel[0]),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat1), .m1_sel_i(sel[1]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .m2_adr_i(adr[2]), .m2_dat_i(wdat[2]), .m2_dat_o(rdat2), .m2_sel_i(sel[2]),
    .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]), .m2_we_i(we[2]), .m2_ack_o(ack[2]), .m2_err_o(err[2]),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_we_o(s_we), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .grant_o(grant)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    sys_rst = 1'b1; s_ack = 1'b0; s_dat_i = 32'hDEAD_BEEF;
    cyc = 3'b000; stb = 3'b000; we = 3'b000;
    for (int i = 0; i < 3; i++) begin adr[i] = 32'd0; wdat[i] = 32'd0; sel[i] = 4'd0; end

    // reset state, ack ignored while idle
    #3;
    check("rst_grant", 32'(grant), 32'd3);
    check("rst_scyc", 32'(s_cyc), 32'd0);
    check("rst_sstb", 32'(s_stb), 32'd0);
    s_ack = 1'b1; #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    s_ack = 1'b0;
    step(); sys_rst = 1'b0;

    // m0 and m2 request together: m0 first, then m2 after one idle cycle
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h0000_1000;
    wdat[0] = 32'hA5A5_0000; sel[0] = 4'h5;
    cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 32'h2222_0000;
    #1;
    check("arb_grant", 32'(grant), 32'd3);
    check("arb_scyc", 32'(s_cyc), 32'd0);
    step();
    check("m0_grant", 32'(grant), 32'd0);
    check("m0_scyc", 32'(s_cyc), 32'd1);
    check("m0_sstb", 32'(s_stb), 32'd1);
    check("m0_sadr", s_adr, 32'h0000_1000);
    check("m0_sdat", s_dat_o, 32'hA5A5_0000);
    check("m0_ssel", 32'(s_sel), 32'h5);
    check("m0_swe", 32'(s_we), 32'd1);
    s_ack = 1'b1; s_dat_i = 32'h1234_5678; #1;
    check("m0_ack", 32'(ack), 32'b001);
    check("m1_rdat", rdat1, 32'h1234_5678);
    check("m2_rdat", rdat2, 32'h1234_5678);
    step(); s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0; #1;
    check("m0_drop_scyc", 32'(s_cyc), 32'd0);
    check("m0_drop_grant", 32'(grant), 32'd0);
    step();
    check("gap_grant", 32'(grant), 32'd3);
    check("gap_scyc", 32'(s_cyc), 32'd0);
    step();
    check("m2_grant", 32'(grant), 32'd2);
    check("m2_sadr", s_adr, 32'h2222_0000);
    s_ack = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0; #1;
    check("m2_ack_drop", 32'(ack), 32'b100);
    step();
    check("m2_end_grant", 32'(grant), 32'd3);
    check("idle_ack_ignored", 32'(ack), 32'd0);
    s_ack = 1'b0;

    // all three continuously request, one ack per tenure
    cyc = 3'b111; stb = 3'b111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_idle", 32'(grant), 32'd3);
      step();
      check($sformatf("rr_grant%0d", i), 32'(grant), 32'(rr_exp[i]));
      s_ack = 1'b1; cyc[rr_exp[i]] = 1'b0; stb[rr_exp[i]] = 1'b0; #1;
      check($sformatf("rr_ack%0d", i), 32'(ack), 32'(3'b001 << rr_exp[i]));
      step();
      s_ack = 1'b0; cyc[rr_exp[i]] = 1'b1; stb[rr_exp[i]] = 1'b1;
    end
    cyc = 3'b000; stb = 3'b000;
    step();

    // m1 holds through 4 strobes while m0 waits
    cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    check("hold_grant", 32'(grant), 32'd1);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      adr[1] = 32'(k * 4 + 32'h100); s_ack = 1'b1;
      if (k == 3) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
      #1;
      check($sformatf("hold_grant%0d", k), 32'(grant), 32'd1);
      check($sformatf("hold_adr%0d", k), s_adr, 32'(k * 4 + 32'h100));
      check($sformatf("hold_ack%0d", k), 32'(ack), 32'b010);
      step();
    end
    s_ack = 1'b0; #1;
    check("hold_gap_grant", 32'(grant), 32'd3);
    check("hold_gap_ack", 32'(ack), 32'd0);
    step();
    check("hold_next_m0", 32'(grant), 32'd0);
    s_ack = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0; #1;
    check("hold_m0_ack", 32'(ack), 32'b001);
    step(); s_ack = 1'b0;

    // m2 never acked: err in 8th strobe cycle, then release
    cyc[2] = 1'b1; stb[2] = 1'b1; #1;
    check("to_idle", 32'(grant), 32'd3);
    step();
    check("to_grant", 32'(grant), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("to_err_c%0d", i), 32'(err), (i == 8) ? 32'b100 : 32'd0);
      check($sformatf("to_scyc_c%0d", i), 32'(s_cyc), 32'd1);
      step();
    end
    cyc = 3'b011; stb = 3'b011; #1;
    check("to_after_scyc", 32'(s_cyc), 32'd0);
    check("to_after_grant", 32'(grant), 32'd3);
    check("to_after_err", 32'(err), 32'd0);
    step();
    check("to_next_m0", 32'(grant), 32'd0);
    s_ack = 1'b1; cyc = 3'b000; stb = 3'b000; #1;
    check("to_m0_ack", 32'(ack), 32'b001);
    step(); s_ack = 1'b0;

    // ack lands in the 8th wait cycle: delivered, no err
    cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    check("late_grant", 32'(grant), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) s_ack = 1'b1;
      #1;
      check($sformatf("late_err_c%0d", i), 32'(err), 32'd0);
      if (i == 8) check("late_ack", 32'(ack), 32'b010);
      step();
    end
    s_ack = 1'b0; #1;
    check("late_still_own", 32'(grant), 32'd1);

    // reset mid-transfer, m0 then wins over m1
    sys_rst = 1'b1; s_ack = 1'b1; #1;
    check("mrst_grant", 32'(grant), 32'd3);
    check("mrst_scyc", 32'(s_cyc), 32'd0);
    check("mrst_sstb", 32'(s_stb), 32'd0);
    check("mrst_ack", 32'(ack), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; sys_rst = 1'b0; s_ack = 1'b0; #1;
    check("mrst_rel_grant", 32'(grant), 32'd3);
    step();
    check("mrst_prio_m0", 32'(grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
